// File: rtl/generic_pkg.sv
// Shared constants and helpers for the generic stream multiplexer and its arbiter.
package generic_pkg;
    localparam int MODE_RR    = 0;
    localparam int MODE_FIXED = 1;

    function automatic int idx_w(input int n);
        return $clog2(n);
    endfunction
endpackage

// File: rtl/rr_arbiter.sv
// Combinational one-hot arbiter: round-robin search upward from ptr, or fixed
// priority (lowest index wins) with ptr ignored.
module rr_arbiter
    import generic_pkg::*;
#(
    parameter int N    = 4,
    parameter int MODE = MODE_RR
) (
    input  logic [N-1:0]          req,
    input  logic [idx_w(N)-1:0]   ptr,
    output logic [N-1:0]          gnt,
    output logic [idx_w(N)-1:0]   gnt_idx
);
    localparam int IW = idx_w(N);

    always_comb begin
        int  base;
        int  k;
        logic found;
        gnt     = '0;
        gnt_idx = '0;
        found   = 1'b0;
        k       = 0;
        // Fixed priority is a round-robin search that always starts at channel 0.
        base    = (MODE == MODE_RR) ? int'(ptr) : 0;
        for (int off = 0; off < N; off++) begin
            k = (base + off) % N;
            if (!found && req[k]) begin
                gnt[k]  = 1'b1;
                gnt_idx = IW'(k);
                found   = 1'b1;
            end
        end
    end
endmodule

// File: rtl/generic_stream_mux.sv
// N-channel valid/ready stream multiplexer with internal arbitration and a
// single registered output stage.
module generic_stream_mux
    import generic_pkg::*;
#(
    parameter int N    = 4,
    parameter int W    = 8,
    parameter int MODE = MODE_RR
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [N-1:0]          in_valid,
    input  logic [N*W-1:0]        in_data,
    output logic [N-1:0]          in_ready,
    output logic                  out_valid,
    output logic [W-1:0]          out_data,
    output logic [idx_w(N)-1:0]   out_chan,
    input  logic                  out_ready
);
    localparam int IW = idx_w(N);

    logic [N-1:0]  gnt;
    logic [IW-1:0] gnt_idx;
    logic          load_en;
    logic          any_req;

    logic          valid_q, valid_d;
    logic [W-1:0]  data_q,  data_d;
    logic [IW-1:0] chan_q,  chan_d;
    logic [IW-1:0] ptr_q,   ptr_d;

    rr_arbiter #(.N(N), .MODE(MODE)) u_arb (
        .req     (in_valid),
        .ptr     (ptr_q),
        .gnt     (gnt),
        .gnt_idx (gnt_idx)
    );

    // Output stage can take a word when empty or draining; never during reset.
    assign load_en = (~valid_q | out_ready) & ~rst;
    assign any_req = |in_valid;

    for (genvar gi = 0; gi < N; gi++) begin : g_rdy
        assign in_ready[gi] = gnt[gi] & load_en;
    end

    always_comb begin
        valid_d = valid_q;
        data_d  = data_q;
        chan_d  = chan_q;
        ptr_d   = ptr_q;
        if (load_en) begin
            if (any_req) begin
                valid_d = 1'b1;
                data_d  = in_data[gnt_idx*W +: W];
                chan_d  = gnt_idx;
                if (MODE == MODE_RR) begin
                    ptr_d = (gnt_idx == IW'(N-1)) ? '0 : gnt_idx + 1'b1;
                end
            end else begin
                valid_d = 1'b0;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            valid_q <= 1'b0;
            data_q  <= '0;
            chan_q  <= '0;
            ptr_q   <= '0;
        end else begin
            valid_q <= valid_d;
            data_q  <= data_d;
            chan_q  <= chan_d;
            ptr_q   <= ptr_d;
        end
    end

    assign out_valid = valid_q;
    assign out_data  = data_q;
    assign out_chan  = chan_q;
endmodule
